// File: rtl/crc8_byte_check_if.sv
// ---------------------------------------------------------------------------
// crc8_byte_check_if
// Purpose : byte stream and status bundle between a byte source (master) and
//           the CRC8 frame checker (slave).
// Signals :
//   in_data  [7:0] byte to check (the CRC byte when in_last=1)   master -> slave
//   in_valid       in_data/in_last valid                         master -> slave
//   in_last        final (CRC) byte of the frame                 master -> slave
//   abort          synchronous frame abort                       master -> slave
//   in_ready       checker can accept a byte this cycle          slave  -> master
//   busy           bits are being shifted                        slave  -> master
//   done           one-cycle pulse, frame check complete         slave  -> master
//   crc_ok         frame passed, valid from done                 slave  -> master
//   crc_out  [7:0] live CRC register (residue after done)        slave  -> master
// ---------------------------------------------------------------------------
interface crc8_byte_check_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       abort;
  logic       in_ready;
  logic       busy;
  logic       done;
  logic       crc_ok;
  logic [7:0] crc_out;

  modport master (
    output in_data, in_valid, in_last, abort,
    input  in_ready, busy, done, crc_ok, crc_out
  );

  modport slave (
    input  in_data, in_valid, in_last, abort,
    output in_ready, busy, done, crc_ok, crc_out
  );
endinterface

// File: rtl/crc8_byte_check.sv
// ---------------------------------------------------------------------------
// crc8_byte_check
// Purpose : receive-side CRC8 checker. Bytes accepted over valid/ready are
//           shifted MSB first through a bit-serial CRC8 engine, one bit per
//           clk. The last byte of a frame is the transmitted CRC; once it is
//           shifted in, a zero residue means the frame is good.
// Parameters:
//   POLY  generator polynomial, implicit x^8 term omitted (default 8'h07)
//   INIT  CRC register value at the start of each frame (default 8'h00)
// Ports:
//   clk        clock, all logic on posedge
//   clr        asynchronous active-high reset
//   bus        crc8_byte_check_if.slave (byte stream, abort, status)
//   err_count  [15:0] saturating count of failed frames (optional)
// Build option:
//   CRC8_CHK_ERRCNT_EN  when defined, adds err_count. Only clr clears it;
//                       abort leaves it untouched.
// ---------------------------------------------------------------------------
module crc8_byte_check #(
  parameter logic [7:0] POLY = 8'h07,
  parameter logic [7:0] INIT = 8'h00
) (
  input  logic clk,
  input  logic clr,
  crc8_byte_check_if.slave bus
`ifdef CRC8_CHK_ERRCNT_EN
  ,
  output logic [15:0] err_count
`endif
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0] state_r;
  logic [7:0] sh_r;
  logic [7:0] crc_r;
  logic [2:0] cnt_r;
  logic       last_r;
  logic       frame_open_r;
  logic       done_r;
  logic       crc_ok_r;

  logic       accept_s;
  logic       fb_s;
  logic [7:0] crc_next_s;
  logic       final_bit_s;

  // Byte acceptance, next CRC value for the current bit and end-of-byte detect.
  always_comb begin
    accept_s    = 1'b0;
    fb_s        = 1'b0;
    crc_next_s  = crc_r;
    final_bit_s = 1'b0;
    if (state_r == ST_IDLE) begin
      accept_s = bus.in_valid & ~bus.abort;
    end else begin
      accept_s = 1'b0;
    end
    fb_s        = crc_r[7] ^ sh_r[7];
    crc_next_s  = {crc_r[6:0], 1'b0} ^ (fb_s ? POLY : 8'h00);
    final_bit_s = (state_r == ST_SHIFT) && (cnt_r == 3'd7);
  end

  // in_ready drops with abort in the same cycle so an abort always wins over
  // a pending accept.
  assign bus.in_ready = (state_r == ST_IDLE) & ~bus.abort;
  assign bus.busy     = (state_r == ST_SHIFT);
  assign bus.done     = done_r;
  assign bus.crc_ok   = crc_ok_r;
  assign bus.crc_out  = crc_r;

  // Frame FSM, shift register and CRC engine.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r      <= ST_IDLE;
      sh_r         <= 8'h00;
      crc_r        <= INIT;
      cnt_r        <= 3'd0;
      last_r       <= 1'b0;
      frame_open_r <= 1'b0;
      done_r       <= 1'b0;
      crc_ok_r     <= 1'b0;
    end else if (bus.abort) begin
      state_r      <= ST_IDLE;
      crc_r        <= INIT;
      cnt_r        <= 3'd0;
      frame_open_r <= 1'b0;
      done_r       <= 1'b0;
      crc_ok_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            sh_r    <= bus.in_data;
            last_r  <= bus.in_last;
            cnt_r   <= 3'd0;
            state_r <= ST_SHIFT;
            // First byte of a frame: restart the CRC. Until then crc_out
            // keeps showing the previous frame's residue.
            if (!frame_open_r) begin
              crc_r        <= INIT;
              frame_open_r <= 1'b1;
              crc_ok_r     <= 1'b0;
            end
          end
        end
        ST_SHIFT: begin
          crc_r <= crc_next_s;
          sh_r  <= {sh_r[6:0], 1'b0};
          cnt_r <= cnt_r + 3'd1;
          if (final_bit_s) begin
            state_r <= ST_IDLE;
            if (last_r) begin
              done_r       <= 1'b1;
              crc_ok_r     <= (crc_next_s == 8'h00);
              frame_open_r <= 1'b0;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef CRC8_CHK_ERRCNT_EN
  // Saturating count of frames whose residue is non-zero.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      err_count <= 16'h0000;
    end else if (!bus.abort && final_bit_s && last_r &&
                 (crc_next_s != 8'h00) && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_crc8_byte_check.sv
module tb_crc8_byte_check;
  logic clk = 1'b0;
  logic clr = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   exp_err = 0;

  crc8_byte_check_if bus ();
`ifdef CRC8_CHK_ERRCNT_EN
  logic [15:0] err_count;
`endif

  crc8_byte_check #(.POLY(8'h07), .INIT(8'h00)) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
`ifdef CRC8_CHK_ERRCNT_EN
    ,
    .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // stream under test and what the DUT reported
  logic [7:0] byte_q[$];
  bit         last_q[$];
  int         acc_q[$];
  int         done_q[$];
  bit         ok_q[$];
  logic [7:0] res_q[$];
  // expectations from the reference model
  bit         exp_ok_q[$];
  logic [7:0] exp_res_q[$];
  int         fstart_q[$];
  int         flen_q[$];

  // CRC8 (poly 0x07, init 0) as polynomial long division, byte at a time
  function automatic logic [7:0] model_residue(input int s, input int e);
    int c;
    c = 0;
    for (int i = s; i <= e; i++) begin
      c = c ^ int'(byte_q[i]);
      for (int k = 0; k < 8; k++) begin
        if (c >= 128) c = ((c * 2) ^ 7) % 256;
        else          c = (c * 2) % 256;
      end
    end
    return 8'(c);
  endfunction

  function automatic void build_expect();
    int s;
    logic [7:0] r;
    s = 0;
    exp_ok_q.delete(); exp_res_q.delete(); fstart_q.delete(); flen_q.delete();
    for (int i = 0; i < byte_q.size(); i++) begin
      if (last_q[i]) begin
        r = model_residue(s, i);
        exp_res_q.push_back(r);
        exp_ok_q.push_back(r == 8'h00);
        fstart_q.push_back(s);
        flen_q.push_back(i - s + 1);
        if (r != 8'h00 && exp_err < 65535) exp_err++;
        s = i + 1;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feed byte_q/last_q; gaps randomly drops in_valid between bytes.
  task automatic run_stream(input bit gaps);
    int idx, budget, nlast;
    bit will_acc;
    idx = 0; budget = 0; nlast = 0;
    acc_q.delete(); done_q.delete(); ok_q.delete(); res_q.delete();
    foreach (last_q[i]) if (last_q[i]) nlast++;
    while ((idx < byte_q.size() || done_q.size() < nlast) && budget < 3000) begin
      if (idx < byte_q.size() && !(gaps && $urandom_range(0, 3) == 0)) begin
        bus.in_valid = 1'b1; bus.in_data = byte_q[idx]; bus.in_last = last_q[idx];
      end else begin
        bus.in_valid = 1'b0; bus.in_data = 8'($urandom); bus.in_last = 1'($urandom);
      end
      will_acc = bus.in_valid && bus.in_ready;
      tick();
      budget++;
      if (will_acc) begin acc_q.push_back(cyc); idx++; end
      if (bus.done === 1'b1) begin
        done_q.push_back(cyc); ok_q.push_back(bus.crc_ok); res_q.push_back(bus.crc_out);
      end
    end
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    checks++;
    if (budget >= 3000) begin
      errors++; $display("FAIL stream_timeout accepted=%0d of %0d dones=%0d of %0d", idx, byte_q.size(), done_q.size(), nlast);
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_last = 1'b0; bus.abort = 1'b0;
    clr = 1'b1;
    #2;
    checks++;
    if ({bus.in_ready, bus.busy, bus.done, bus.crc_ok} !== 4'b1000) begin
      errors++; $display("FAIL reset_flags got ready/busy/done/ok=%b exp=1000", {bus.in_ready, bus.busy, bus.done, bus.crc_ok});
    end
    checks++;
    if (bus.crc_out !== 8'h00) begin errors++; $display("FAIL reset_crc_out got=%h exp=00", bus.crc_out); end
    tick(); tick();
    clr = 1'b0; exp_err = 0;
    tick();
    checks++;
    if ({bus.in_ready, bus.busy, bus.done} !== 3'b100 || bus.crc_out !== 8'h00) begin
      errors++; $display("FAIL post_reset_idle got ready/busy/done=%b crc=%h exp=100 00", {bus.in_ready, bus.busy, bus.done}, bus.crc_out);
    end
  endtask

  task automatic test_good_frame();
    byte_q = '{8'h01, 8'h07}; last_q = '{1'b0, 1'b1};
    build_expect(); run_stream(1'b0);
    checks++;
    if (done_q.size() !== 1) begin errors++; $display("FAIL good_done_count got=%0d exp=1", done_q.size()); end
    if (done_q.size() >= 1 && acc_q.size() >= 1) begin
      checks++;
      if (done_q[0] - acc_q[0] !== 17) begin errors++; $display("FAIL good_latency got=%0d exp=17", done_q[0] - acc_q[0]); end
      checks++;
      if (ok_q[0] !== 1'b1 || res_q[0] !== 8'h00) begin errors++; $display("FAIL good_result got ok=%b crc=%h exp ok=1 crc=00", ok_q[0], res_q[0]); end
    end
    tick(); tick();
    checks++;
    if (bus.done !== 1'b0 || bus.crc_ok !== 1'b1 || bus.crc_out !== 8'h00) begin
      errors++; $display("FAIL good_hold got done=%b ok=%b crc=%h exp done=0 ok=1 crc=00", bus.done, bus.crc_ok, bus.crc_out);
    end
  endtask

  task automatic test_bad_frame();
    byte_q = '{8'h01, 8'h06}; last_q = '{1'b0, 1'b1};
    build_expect(); run_stream(1'b0);
    checks++;
    if (done_q.size() !== 1) begin errors++; $display("FAIL bad_done_count got=%0d exp=1", done_q.size()); end
    if (done_q.size() >= 1) begin
      checks++;
      if (ok_q[0] !== 1'b0 || res_q[0] !== 8'h07) begin errors++; $display("FAIL bad_result got ok=%b crc=%h exp ok=0 crc=07", ok_q[0], res_q[0]); end
    end
`ifdef CRC8_CHK_ERRCNT_EN
    checks++;
    if (err_count !== 16'd1) begin errors++; $display("FAIL bad_err_count got=%0d exp=1", err_count); end
`endif
  endtask

  task automatic test_check_string();
    byte_q.delete(); last_q.delete();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 9; i++) begin byte_q.push_back(8'h31 + 8'(i)); last_q.push_back(1'b0); end
      byte_q.push_back(r == 0 ? 8'hF4 : 8'hF5); last_q.push_back(1'b1);
    end
    build_expect(); run_stream(1'b1);
    checks++;
    if (done_q.size() !== 2) begin errors++; $display("FAIL str_done_count got=%0d exp=2", done_q.size()); end
    if (done_q.size() >= 2) begin
      checks++;
      if (ok_q[0] !== 1'b1) begin errors++; $display("FAIL str_good got ok=%b crc=%h exp ok=1", ok_q[0], res_q[0]); end
      checks++;
      if (ok_q[1] !== 1'b0 || res_q[1] !== 8'h07) begin errors++; $display("FAIL str_bad got ok=%b crc=%h exp ok=0 crc=07", ok_q[1], res_q[1]); end
    end
  endtask

  task automatic test_random();
    int s, len;
    logic [7:0] c;
    for (int pass = 0; pass < 2; pass++) begin
      byte_q.delete(); last_q.delete();
      for (int f = 0; f < 14; f++) begin
        s = byte_q.size();
        len = $urandom_range(0, 5);
        for (int i = 0; i < len; i++) begin byte_q.push_back(8'($urandom)); last_q.push_back(1'b0); end
        c = model_residue(s, s + len - 1);
        if ($urandom_range(0, 2) == 0) c = c ^ 8'($urandom_range(1, 255));
        byte_q.push_back(c); last_q.push_back(1'b1);
      end
      build_expect(); run_stream(pass == 1);
      checks++;
      if (done_q.size() !== exp_res_q.size()) begin errors++; $display("FAIL rand_done_count got=%0d exp=%0d", done_q.size(), exp_res_q.size()); end
      for (int k = 0; k < done_q.size() && k < exp_res_q.size(); k++) begin
        checks++;
        if (ok_q[k] !== exp_ok_q[k] || res_q[k] !== exp_res_q[k]) begin
          errors++; $display("FAIL rand_frame%0d got ok=%b crc=%h exp ok=%b crc=%h", k, ok_q[k], res_q[k], exp_ok_q[k], exp_res_q[k]);
        end
        if (pass == 0) begin
          checks++;
          if (done_q[k] - acc_q[fstart_q[k]] !== 9 * flen_q[k] - 1) begin
            errors++; $display("FAIL rand_latency%0d got=%0d exp=%0d", k, done_q[k] - acc_q[fstart_q[k]], 9 * flen_q[k] - 1);
          end
        end
      end
    end
`ifdef CRC8_CHK_ERRCNT_EN
    checks++;
    if (err_count !== 16'(exp_err)) begin errors++; $display("FAIL rand_err_count got=%0d exp=%0d", err_count, exp_err); end
`endif
  endtask

  task automatic test_abort();
    int nd;
    bus.in_valid = 1'b1; bus.in_data = 8'h01; bus.in_last = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    repeat (8) tick();
    bus.in_valid = 1'b1; bus.in_data = 8'h07; bus.in_last = 1'b1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL abort_pre_ready got=%b exp=1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    bus.abort = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL abort_shifting got busy=%b ready=%b exp 1 0", bus.busy, bus.in_ready); end
    tick();
    checks++;
    if ({bus.busy, bus.done, bus.crc_ok} !== 3'b000 || bus.crc_out !== 8'h00) begin
      errors++; $display("FAIL abort_idle got busy/done/ok=%b crc=%h exp 000 00", {bus.busy, bus.done, bus.crc_ok}, bus.crc_out);
    end
    bus.in_valid = 1'b1; bus.in_data = 8'h55; bus.in_last = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL abort_ready got=%b exp=0", bus.in_ready); end
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_blocks_accept got busy=%b exp=0", bus.busy); end
    bus.abort = 1'b0; bus.in_valid = 1'b0;
    nd = 0;
    repeat (12) begin tick(); if (bus.done === 1'b1) nd++; end
    checks++;
    if (nd !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", nd); end
    byte_q = '{8'h01, 8'h07}; last_q = '{1'b0, 1'b1};
    build_expect(); run_stream(1'b0);
    checks++;
    if (done_q.size() !== 1 || ok_q.size() < 1 || ok_q[0] !== 1'b1 || res_q[0] !== 8'h00) begin
      errors++; $display("FAIL abort_next_frame got dones=%0d ok=%b exp dones=1 ok=1", done_q.size(), ok_q.size() > 0 ? ok_q[0] : 1'b0);
    end
  endtask

  task automatic test_reset_midshift();
    int nd;
    bus.in_valid = 1'b1; bus.in_data = 8'hAB; bus.in_last = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    clr = 1'b1;
    #1;
    checks++;
    if ({bus.in_ready, bus.busy, bus.done, bus.crc_ok} !== 4'b1000 || bus.crc_out !== 8'h00) begin
      errors++; $display("FAIL midshift_reset got ready/busy/done/ok=%b crc=%h exp 1000 00", {bus.in_ready, bus.busy, bus.done, bus.crc_ok}, bus.crc_out);
    end
    #3;
    clr = 1'b0; exp_err = 0;
    nd = 0;
    repeat (12) begin tick(); if (bus.done === 1'b1) nd++; end
    checks++;
    if (nd !== 0) begin errors++; $display("FAIL midshift_no_done got=%0d exp=0", nd); end
`ifdef CRC8_CHK_ERRCNT_EN
    checks++;
    if (err_count !== 16'd0) begin errors++; $display("FAIL midshift_err_count got=%0d exp=0", err_count); end
`endif
  endtask

  task automatic test_back_to_back();
    byte_q = '{8'h01, 8'h07, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hF4};
    last_q = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    build_expect(); run_stream(1'b0);
    checks++;
    if (acc_q.size() !== 12 || done_q.size() !== 2) begin
      errors++; $display("FAIL b2b_counts got acc=%0d done=%0d exp 12 2", acc_q.size(), done_q.size());
    end
    for (int i = 1; i < acc_q.size(); i++) begin
      checks++;
      if (acc_q[i] - acc_q[i-1] !== 9) begin errors++; $display("FAIL b2b_spacing%0d got=%0d exp=9", i, acc_q[i] - acc_q[i-1]); end
    end
    if (done_q.size() == 2 && acc_q.size() == 12) begin
      checks++;
      if (acc_q[2] !== done_q[0] + 1) begin errors++; $display("FAIL b2b_overlap got acc=%0d exp=%0d", acc_q[2], done_q[0] + 1); end
      checks++;
      if (ok_q[0] !== 1'b1 || ok_q[1] !== 1'b1) begin errors++; $display("FAIL b2b_ok got=%b%b exp=11", ok_q[0], ok_q[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_frame();
    test_check_string();
    test_random();
    test_abort();
    test_reset_midshift();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
